// File: rtl/sr_cmd_sequencer.sv
// Command stage in front of an SR flip-flop: synchronises and debounces set/clear
// requests, arbitrates them, and issues spaced, mutually exclusive s/r pulses.
module sr_cmd_sequencer #(
    parameter int unsigned DB_CYCLES    = 4,
    parameter int unsigned PULSE_LEN    = 1,
    parameter int unsigned GAP_LEN      = 2,
    parameter bit          CLR_PRIORITY = 1'b1,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_req,
    input  logic             clr_req,
    input  logic             q_fb,
    output logic             s,
    output logic             r,
    output logic             busy,
    output logic             drop,
    output logic [CNT_W-1:0] cmd_cnt
);

    localparam int unsigned DW = $clog2(DB_CYCLES + 1);
    localparam int unsigned PW = $clog2(PULSE_LEN + 1);
    localparam int unsigned GW = $clog2(GAP_LEN + 2);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    // Channel index 0 is set, index 1 is clear.
    logic [1:0]         req_raw;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         db_lvl;
    logic [1:0]         db_prev;
    logic [1:0][DW-1:0] db_cnt;
    logic [1:0]         pend;
    logic [1:0]         rise;

    state_t             state;
    logic [PW-1:0]      pcnt;
    logic [GW-1:0]      gcnt;

    logic               deciding;
    logic               pick_clr;
    logic               both;
    logic               redundant;

    assign req_raw = {clr_req, set_req};
    assign rise    = db_lvl & ~db_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            db_lvl  <= '0;
            db_prev <= '0;
            db_cnt  <= '0;
        end else begin
            sync1   <= req_raw;
            sync2   <= sync1;
            db_prev <= db_lvl;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        deciding  = (state == IDLE) && (pend != 2'b00);
        pick_clr  = pend[1] && (!pend[0] || CLR_PRIORITY);
        both      = pend[1] && pend[0];
        redundant = pick_clr ? !q_fb : q_fb;
    end

    // A decision consumes every pending flag; an event landing on that same edge survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            pend <= (deciding ? 2'b00 : pend) | rise;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            s       <= 1'b0;
            r       <= 1'b0;
            busy    <= 1'b0;
            drop    <= 1'b0;
            cmd_cnt <= '0;
            pcnt    <= '0;
            gcnt    <= '0;
        end else begin
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (deciding) begin
                        drop <= both || redundant;
                        if (!redundant) begin
                            state <= PULSE;
                            busy  <= 1'b1;
                            s     <= !pick_clr;
                            r     <= pick_clr;
                            pcnt  <= '0;
                            if (cmd_cnt != '1) begin
                                cmd_cnt <= cmd_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                PULSE: begin
                    if (pcnt == PW'(PULSE_LEN - 1)) begin
                        s    <= 1'b0;
                        r    <= 1'b0;
                        gcnt <= '0;
                        if (GAP_LEN == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                GAP: begin
                    if (gcnt == GW'(GAP_LEN - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    s     <= 1'b0;
                    r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer at default parameters; edge numbers count
// from the first rising edge that samples the newly driven request.
module tb_sr_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_req;
    logic       clr_req;
    logic       q_fb;
    logic       s;
    logic       r;
    logic       busy;
    logic       drop;
    logic [7:0] cmd_cnt;

    int checks = 0;
    int errors = 0;

    int s_n, r_n, busy_n, drop_n;

    sr_cmd_sequencer #(
        .DB_CYCLES   (4),
        .PULSE_LEN   (1),
        .GAP_LEN     (2),
        .CLR_PRIORITY(1'b1),
        .CNT_W       (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .set_req(set_req),
        .clr_req(clr_req),
        .q_fb   (q_fb),
        .s      (s),
        .r      (r),
        .busy   (busy),
        .drop   (drop),
        .cmd_cnt(cmd_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, sample 1ns later and accumulate output activity.
    task automatic tick();
        @(posedge clk);
        #1;
        s_n    += int'(s);
        r_n    += int'(r);
        busy_n += int'(busy);
        drop_n += int'(drop);
    endtask

    task automatic clear_counts();
        s_n = 0; r_n = 0; busy_n = 0; drop_n = 0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0; set_req = 1'b0; clr_req = 1'b0; q_fb = 1'b0;
        tick(); tick();
        check({tag, "_rst_s"}, int'(s), 0);
        check({tag, "_rst_busy"}, int'(busy), 0);
        check({tag, "_rst_cnt"}, int'(cmd_cnt), 0);
        rst = 1'b1;
        clear_counts();
    endtask

    initial begin
        rst = 1'b0; set_req = 1'b0; clr_req = 1'b0; q_fb = 1'b0;
        clear_counts();
        #3;
        check("async_rst_r", int'(r), 0);
        check("async_rst_drop", int'(drop), 0);

        // 1: single set, latency and pulse shape
        do_reset("t1");
        set_req = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 7) check("t1_s_e7", int'(s), 0);
            if (e == 8) check("t1_s_e8", int'(s), 1);
            if (e == 9) check("t1_s_e9", int'(s), 0);
        end
        check("t1_s_cnt", s_n, 1);
        check("t1_busy_cnt", busy_n, 3);
        check("t1_r_cnt", r_n, 0);
        check("t1_drop_cnt", drop_n, 0);
        check("t1_cmd_cnt", int'(cmd_cnt), 1);

        // 2: glitches of 3 cycles never pass the debouncer
        do_reset("t2");
        for (int k = 0; k < 5; k++) begin
            set_req = 1'b1;
            for (int e = 0; e < 3; e++) tick();
            set_req = 1'b0;
            for (int e = 0; e < 5; e++) tick();
        end
        for (int e = 0; e < 10; e++) tick();
        check("t2_s_cnt", s_n, 0);
        check("t2_drop_cnt", drop_n, 0);
        check("t2_cmd_cnt", int'(cmd_cnt), 0);

        // 3: simultaneous requests, clear wins, set is dropped
        do_reset("t3");
        q_fb = 1'b1;
        set_req = 1'b1; clr_req = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 8) begin
                check("t3_drop_e8", int'(drop), 1);
                check("t3_r_e8", int'(r), 1);
            end
        end
        check("t3_r_cnt", r_n, 1);
        check("t3_drop_cnt", drop_n, 1);
        check("t3_s_cnt", s_n, 0);
        check("t3_cmd_cnt", int'(cmd_cnt), 1);

        // 4: redundant set is dropped without a pulse
        do_reset("t4");
        q_fb = 1'b1;
        set_req = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 8) check("t4_drop_e8", int'(drop), 1);
        end
        check("t4_drop_cnt", drop_n, 1);
        check("t4_s_cnt", s_n, 0);
        check("t4_busy_cnt", busy_n, 0);
        check("t4_cmd_cnt", int'(cmd_cnt), 0);

        // 5: clear pending during the gap fires right after the gap
        do_reset("t5");
        set_req = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 2) clr_req = 1'b1;
            if (e == 8) begin
                check("t5_s_e8", int'(s), 1);
                q_fb = 1'b1;
            end
            if (e == 11) check("t5_r_e11", int'(r), 0);
            if (e == 12) check("t5_r_e12", int'(r), 1);
            if (e == 13) check("t5_r_e13", int'(r), 0);
        end
        check("t5_s_cnt", s_n, 1);
        check("t5_r_cnt", r_n, 1);
        check("t5_drop_cnt", drop_n, 0);
        check("t5_cmd_cnt", int'(cmd_cnt), 2);

        // 6: reset during the pulse aborts it; held request re-issues
        do_reset("t6");
        set_req = 1'b1;
        for (int e = 1; e <= 8; e++) tick();
        check("t6_s_before", int'(s), 1);
        #1;
        rst = 1'b0;
        #1;
        check("t6_s_async", int'(s), 0);
        check("t6_busy_async", int'(busy), 0);
        check("t6_cnt_async", int'(cmd_cnt), 0);
        #1;
        rst = 1'b1;
        clear_counts();
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 7) check("t6_s_e7", int'(s), 0);
            if (e == 8) check("t6_s_e8", int'(s), 1);
        end
        check("t6_s_cnt", s_n, 1);
        check("t6_cmd_cnt", int'(cmd_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
